// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory scheduler: in-order store buffer plus load path,
// one registered command per cycle, loads blocked on same-word buffered stores.
module dmem_port_arbiter #(
  parameter int unsigned SB_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          st_valid,
  output logic                          st_ready,
  input  logic [31:0]                   st_addr,
  input  logic [31:0]                   st_data,
  input  logic                          st_sh,
  input  logic [4:0]                    st_rob,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [31:0]                   ld_addr,
  input  logic [2:0]                    ld_func3,
  input  logic [6:0]                    ld_pd,
  input  logic [4:0]                    ld_rob,
  input  logic                          flush,
  output logic                          mem_we,
  output logic                          mem_re,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          mem_sh,
  output logic [2:0]                    mem_func3,
  output logic [6:0]                    mem_pd,
  output logic [4:0]                    mem_rob,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          idle
);

  localparam int unsigned CW = $clog2(SB_DEPTH + 1);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [31:0]   sb_addr [SB_DEPTH];
  logic [31:0]   sb_data [SB_DEPTH];
  logic          sb_sh   [SB_DEPTH];
  logic [4:0]    sb_rob  [SB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic push;
  logic hazard;
  logic st_grant;
  logic ld_grant;
  logic empty;
  logic full;

  assign empty    = (count == '0);
  assign full     = (count == CW'(SB_DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && st_ready;
  assign sb_count = count;
  assign idle     = empty && !mem_we && !mem_re;
  assign ld_ready = ld_grant;

  // Word-address match of the load against every live entry and the incoming store
  always_comb begin
    logic [PW-1:0] offs;
    hazard = push && (st_addr[31:2] == ld_addr[31:2]);
    for (int i = 0; i < SB_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ((CW'(offs) < count) && (sb_addr[i][31:2] == ld_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  // Grant decision: drain the head when forced or when no load competes
  always_comb begin
    st_grant = 1'b0;
    ld_grant = 1'b0;
    if (!empty && (flush || full || hazard ||
                   (starve_cnt == SW'(STARVE_MAX)) || !ld_valid)) begin
      st_grant = 1'b1;
    end else if (!flush && ld_valid && !hazard) begin
      ld_grant = 1'b1;
    end
  end

  // Store buffer payload storage; contents are meaningless outside the live window
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= st_addr;
      sb_data[wr_ptr] <= st_data;
      sb_sh[wr_ptr]   <= st_sh;
      sb_rob[wr_ptr]  <= st_rob;
    end
  end

  // FIFO pointers, occupancy and load-starvation counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (st_grant) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(st_grant);
      if (st_grant || flush || empty) begin
        starve_cnt <= '0;
      end else if (ld_grant && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Command register toward the memory port; unused fields hold their last value
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sh    <= 1'b0;
      mem_func3 <= '0;
      mem_pd    <= '0;
      mem_rob   <= '0;
    end else begin
      mem_we <= st_grant;
      mem_re <= ld_grant;
      if (st_grant) begin
        mem_addr  <= sb_addr[rd_ptr];
        mem_wdata <= sb_data[rd_ptr];
        mem_sh    <= sb_sh[rd_ptr];
        mem_rob   <= sb_rob[rd_ptr];
      end else if (ld_grant) begin
        mem_addr  <= ld_addr;
        mem_func3 <= ld_func3;
        mem_pd    <= ld_pd;
        mem_rob   <= ld_rob;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: queue-based reference model, directed scenarios, random traffic.
module tb_dmem_port_arbiter;

  localparam int unsigned SB_DEPTH   = 4;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned CW         = $clog2(SB_DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid, st_ready, st_sh;
  logic [31:0]   st_addr, st_data;
  logic [4:0]    st_rob;
  logic          ld_valid, ld_ready;
  logic [31:0]   ld_addr;
  logic [2:0]    ld_func3;
  logic [6:0]    ld_pd;
  logic [4:0]    ld_rob;
  logic          flush;
  logic          mem_we, mem_re, mem_sh;
  logic [31:0]   mem_addr, mem_wdata;
  logic [2:0]    mem_func3;
  logic [6:0]    mem_pd;
  logic [4:0]    mem_rob;
  logic [CW-1:0] sb_count;
  logic          idle;

  dmem_port_arbiter #(.SB_DEPTH(SB_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_sh(st_sh), .st_rob(st_rob),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_func3(ld_func3),
    .ld_pd(ld_pd), .ld_rob(ld_rob), .flush(flush),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sh(mem_sh), .mem_func3(mem_func3), .mem_pd(mem_pd), .mem_rob(mem_rob),
    .sb_count(sb_count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        sh;
    logic [4:0]  rob;
  } st_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  st_t         sq[$];
  int          starve;
  bit          last_lg;
  logic        e_we, e_re, e_sh;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_f3;
  logic [6:0]  e_pd;
  logic [4:0]  e_rob;
  string       trace;
  logic [31:0] wlog[$];
  logic [31:0] rlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic clr_log();
    trace = "";
    wlog.delete();
    rlog.delete();
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_sh = 1'b0; st_rob = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_func3 = '0; ld_pd = '0; ld_rob = '0;
    flush = 1'b0;
  endtask

  // Hold reset low for n edges, then check the architected reset state.
  task automatic do_reset(input int n);
    idle_inputs();
    reset = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    sq.delete();
    starve = 0; last_lg = 1'b0;
    e_we = 0; e_re = 0; e_sh = 0; e_addr = '0; e_wdata = '0; e_f3 = '0; e_pd = '0; e_rob = '0;
    chk("rst_mem_we",    32'(mem_we),    32'h0);
    chk("rst_mem_re",    32'(mem_re),    32'h0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_mem_wdata", mem_wdata,      32'h0);
    chk("rst_mem_misc",  32'({mem_sh, mem_func3, mem_pd, mem_rob}), 32'h0);
    chk("rst_sb_count",  32'(sb_count),  32'h0);
    chk("rst_idle",      32'(idle),      32'h1);
    chk("rst_st_ready",  32'(st_ready),  32'h1);
  endtask

  // One clock: check handshake outputs, advance the model, check the command register.
  task automatic step();
    int cnt;
    bit st_rdy, push, hz, sg, lg;
    st_t h;
    #1;
    cnt    = sq.size();
    st_rdy = (cnt != SB_DEPTH);
    push   = st_valid && st_rdy;
    hz     = push && (st_addr[31:2] == ld_addr[31:2]);
    foreach (sq[i]) if (sq[i].a[31:2] == ld_addr[31:2]) hz = 1'b1;
    sg = (cnt > 0) && (flush || cnt == SB_DEPTH || hz || starve == STARVE_MAX || !ld_valid);
    lg = !sg && !flush && ld_valid && !hz;
    chk("st_ready", 32'(st_ready), 32'(st_rdy));
    chk("ld_ready", 32'(ld_ready), 32'(lg));
    e_we = 1'b0;
    e_re = 1'b0;
    if (sg) begin
      h = sq.pop_front();
      e_we = 1'b1; e_addr = h.a; e_wdata = h.d; e_sh = h.sh; e_rob = h.rob;
    end else if (lg) begin
      e_re = 1'b1; e_addr = ld_addr; e_f3 = ld_func3; e_pd = ld_pd; e_rob = ld_rob;
    end
    if (push) sq.push_back('{a: st_addr, d: st_data, sh: st_sh, rob: st_rob});
    if (sg || flush || cnt == 0) starve = 0;
    else if (lg && starve < STARVE_MAX) starve++;
    last_lg = lg;
    @(posedge clk);
    #1;
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("mem_re",    32'(mem_re),    32'(e_re));
    chk("mem_addr",  mem_addr,       e_addr);
    chk("mem_wdata", mem_wdata,      e_wdata);
    chk("mem_sh",    32'(mem_sh),    32'(e_sh));
    chk("mem_func3", 32'(mem_func3), 32'(e_f3));
    chk("mem_pd",    32'(mem_pd),    32'(e_pd));
    chk("mem_rob",   32'(mem_rob),   32'(e_rob));
    chk("sb_count",  32'(sb_count),  32'(sq.size()));
    chk("idle",      32'(idle),      32'(sq.size() == 0 && !e_we && !e_re));
    if (mem_we) begin trace = {trace, "W"}; wlog.push_back(mem_addr); end
    if (mem_re) begin trace = {trace, "R"}; rlog.push_back(mem_addr); end
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d; st_sh = 1'b0; st_rob = 5'(a[6:2]);
  endtask

  task automatic set_ld(input logic [31:0] a, input logic [2:0] f3, input logic [6:0] pd);
    ld_valid = 1'b1; ld_addr = a; ld_func3 = f3; ld_pd = pd; ld_rob = 5'(pd);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset then idle
    do_reset(2);
    clr_log();
    repeat (3) step();
    chk_s("idle_trace", trace, "");

    // Store burst drains in acceptance order
    do_reset(1);
    clr_log();
    for (int i = 0; i < 4; i++) begin
      push_st(32'h10 + 32'(4 * i), 32'hA + 32'(i));
      step();
    end
    idle_inputs();
    repeat (3) step();
    chk_s("burst_trace", trace, "WWWW");
    chk("burst_n", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("burst_addr", wlog[i], 32'h10 + 32'(4 * i));
    chk("burst_cnt", 32'(sb_count), 32'h0);

    // Load priority then forced drain after STARVE_MAX loads
    do_reset(1);
    clr_log();
    push_st(32'h100, 32'h1);
    step();
    st_valid = 1'b0;
    set_ld(32'h200, 3'b010, 7'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_lg) ld_addr = ld_addr + 32'd4;
    end
    ld_valid = 1'b0;
    chk_s("starve_trace", trace, "RRRWR");
    if (wlog.size() > 0) chk("starve_waddr", wlog[0], 32'h100);
    if (rlog.size() > 3) chk("starve_raddr", rlog[3], 32'h20C);

    // Same-word hazard blocks a byte load until the store issues
    do_reset(1);
    clr_log();
    push_st(32'h40, 32'hDEADBEEF);
    step();
    st_valid = 1'b0;
    set_ld(32'h42, 3'b100, 7'd9);
    #1 chk("haz_ld_ready", 32'(ld_ready), 32'h0);
    step();
    step();
    ld_valid = 1'b0;
    chk_s("haz_trace", trace, "WR");
    if (rlog.size() > 0) chk("haz_raddr", rlog[0], 32'h42);
    chk("haz_wdata", mem_wdata, 32'hDEADBEEF);

    // Flush kills the load but not buffered stores
    do_reset(1);
    clr_log();
    push_st(32'h500, 32'h1); set_ld(32'h300, 3'b010, 7'd2); step();
    push_st(32'h504, 32'h2); set_ld(32'h304, 3'b010, 7'd3); step();
    st_valid = 1'b0; set_ld(32'h80, 3'b010, 7'd5); flush = 1'b1;
    step();
    flush = 1'b0; ld_valid = 1'b0;
    repeat (2) step();
    chk_s("flush_trace", trace, "RRWW");
    chk("flush_nre", 32'(rlog.size()), 32'd2);
    if (wlog.size() > 1) chk("flush_w1", wlog[1], 32'h504);

    // Reset mid-drain discards remaining stores
    do_reset(1);
    clr_log();
    for (int i = 0; i < 3; i++) begin
      push_st(32'h600 + 32'(4 * i), 32'(i));
      set_ld(32'h700 + 32'(4 * i), 3'b010, 7'(i));
      step();
    end
    idle_inputs();
    step();
    chk_s("mid_pre", trace, "RRRW");
    do_reset(1);
    clr_log();
    repeat (5) step();
    chk_s("mid_post", trace, "");

    // Random traffic against the model
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1);
        continue;
      end
      st_valid = ($urandom_range(0, 2) != 0);
      st_addr  = 32'h1000 + 32'($urandom_range(0, 31));
      st_data  = $urandom;
      st_sh    = 1'($urandom);
      st_rob   = 5'($urandom);
      if (!ld_valid || last_lg || flush) begin
        ld_valid = ($urandom_range(0, 1) == 1);
        ld_addr  = 32'h1000 + 32'($urandom_range(0, 31));
        ld_func3 = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b010;
        ld_pd    = 7'($urandom);
        ld_rob   = 5'($urandom);
      end
      flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
